// File: rtl/vend_ctrl_multi.sv
// rtl/vend_ctrl_multi.sv - multi-product vending transaction controller
// Purpose: collects coin credit, checks a selection against a flattened per-product
//   price table, dispenses, hands out change with an ack handshake, accumulates a
//   saturating sales total and raises a timed alarm on a bad or under-funded selection.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   coin_valid/coin_value         coin strobe and value
//   sel_valid/sel_code            selection strobe and product code
//   cancel, change_ack            refund request, change paid-out handshake
//   sales_clear                   clear sales_total (any state)
//   price_table                   price of product i at [i*AMT_W +: AMT_W]
//   credit, coin_reject           current credit, rejected-coin pulse
//   dispense, dispense_code       release pulse and held product code
//   change_valid, change_amount   change offer, held until change_ack
//   alarm, sales_total            selection alarm, saturating sales accumulator
module vend_ctrl_multi #(
  parameter int NUM_PROD    = 8,
  parameter int CODE_W      = 4,
  parameter int AMT_W       = 8,
  parameter int SALES_W     = 16,
  parameter int MAX_CREDIT  = 99,
  parameter int TIMEOUT_CYC = 1000,
  parameter int ALARM_CYC   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      coin_valid,
  input  logic [AMT_W-1:0]          coin_value,
  input  logic                      sel_valid,
  input  logic [CODE_W-1:0]         sel_code,
  input  logic                      cancel,
  input  logic                      change_ack,
  input  logic                      sales_clear,
  input  logic [NUM_PROD*AMT_W-1:0] price_table,
  output logic [AMT_W-1:0]          credit,
  output logic                      coin_reject,
  output logic                      dispense,
  output logic [CODE_W-1:0]         dispense_code,
  output logic                      change_valid,
  output logic [AMT_W-1:0]          change_amount,
  output logic                      alarm,
  output logic [SALES_W-1:0]        sales_total
);

  typedef enum logic [2:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE, S_ALARM} state_t;

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int ALM_W = $clog2(ALARM_CYC + 1);
  localparam logic [AMT_W:0] MAX_C = (AMT_W + 1)'(MAX_CREDIT);

  state_t              state_q;
  logic [AMT_W-1:0]    credit_q, price_q, change_amount_q;
  logic [CODE_W-1:0]   dispense_code_q;
  logic                coin_reject_q, dispense_q, change_valid_q, alarm_q;
  logic [SALES_W-1:0]  sales_q, sales_d;
  logic [TMR_W-1:0]    idle_tmr_q;
  logic [ALM_W-1:0]    alarm_cnt_q;

  logic [AMT_W-1:0]    sel_price;
  logic                sel_in_range;
  logic [AMT_W:0]      coin_sum;
  logic [AMT_W-1:0]    remainder;
  logic [SALES_W-1:0]  sales_base;
  logic [SALES_W:0]    sales_sum;
  logic                strobe;

  always_comb begin
    sel_price = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (sel_code == CODE_W'(i)) sel_price = price_table[i*AMT_W +: AMT_W];
    end
  end

  assign sel_in_range = (int'(sel_code) < NUM_PROD);
  // One extra bit so an overflowing sum is still compared correctly against the ceiling.
  assign coin_sum     = {1'b0, credit_q} + {1'b0, coin_value};
  assign remainder    = credit_q - price_q;
  assign strobe       = coin_valid | sel_valid | cancel;

  // Clear is applied before the VEND add, so a clear in the VEND cycle leaves just the price.
  always_comb begin
    sales_base = sales_clear ? '0 : sales_q;
    sales_sum  = {1'b0, sales_base} + (SALES_W + 1)'(price_q);
    sales_d    = sales_base;
    if (state_q == S_VEND) sales_d = sales_sum[SALES_W] ? '1 : sales_sum[SALES_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      credit_q        <= '0;
      price_q         <= '0;
      change_amount_q <= '0;
      dispense_code_q <= '0;
      coin_reject_q   <= 1'b0;
      dispense_q      <= 1'b0;
      change_valid_q  <= 1'b0;
      alarm_q         <= 1'b0;
      sales_q         <= '0;
      idle_tmr_q      <= '0;
      alarm_cnt_q     <= '0;
    end else begin
      coin_reject_q <= 1'b0;
      dispense_q    <= 1'b0;
      sales_q       <= sales_d;
      case (state_q)
        S_IDLE: begin
          if (coin_valid) begin
            if ({1'b0, coin_value} > MAX_C) begin
              coin_reject_q <= 1'b1;
            end else begin
              credit_q   <= coin_value;
              idle_tmr_q <= '0;
              state_q    <= S_CREDIT;
            end
          end
        end
        S_CREDIT: begin
          idle_tmr_q <= strobe ? '0 : idle_tmr_q + TMR_W'(1);
          if (cancel) begin
            coin_reject_q   <= coin_valid;
            change_amount_q <= credit_q;
            change_valid_q  <= 1'b1;
            state_q         <= S_CHANGE;
          end else if (sel_valid) begin
            coin_reject_q <= coin_valid;
            if (!sel_in_range || credit_q < sel_price) begin
              alarm_q     <= 1'b1;
              alarm_cnt_q <= '0;
              state_q     <= S_ALARM;
            end else begin
              // Dispense is raised here so it is high during the single VEND cycle.
              dispense_q      <= 1'b1;
              dispense_code_q <= sel_code;
              price_q         <= sel_price;
              state_q         <= S_VEND;
            end
          end else if (coin_valid) begin
            if (coin_sum > MAX_C) coin_reject_q <= 1'b1;
            else                  credit_q      <= coin_sum[AMT_W-1:0];
          end else if (idle_tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
            change_amount_q <= credit_q;
            change_valid_q  <= 1'b1;
            state_q         <= S_CHANGE;
          end
        end
        S_VEND: begin
          coin_reject_q <= coin_valid;
          credit_q      <= remainder;
          if (remainder != '0) begin
            change_amount_q <= remainder;
            change_valid_q  <= 1'b1;
            state_q         <= S_CHANGE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CHANGE: begin
          coin_reject_q <= coin_valid;
          if (change_ack) begin
            credit_q       <= '0;
            change_valid_q <= 1'b0;
            state_q        <= S_IDLE;
          end
        end
        S_ALARM: begin
          coin_reject_q <= coin_valid;
          if (alarm_cnt_q == ALM_W'(ALARM_CYC - 1)) begin
            alarm_q    <= 1'b0;
            idle_tmr_q <= '0;
            state_q    <= S_CREDIT;
          end else begin
            alarm_cnt_q <= alarm_cnt_q + ALM_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign credit        = credit_q;
  assign coin_reject   = coin_reject_q;
  assign dispense      = dispense_q;
  assign dispense_code = dispense_code_q;
  assign change_valid  = change_valid_q;
  assign change_amount = change_amount_q;
  assign alarm         = alarm_q;
  assign sales_total   = sales_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb/tb_vend_ctrl_multi.sv - self-checking bench for vend_ctrl_multi
module tb_vend_ctrl_multi;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        coin_valid, sel_valid, cancel, change_ack, sales_clear;
  logic [7:0]  coin_value;
  logic [3:0]  sel_code;
  logic [63:0] price_table;
  logic [7:0]  credit, change_amount;
  logic        coin_reject, dispense, change_valid, alarm;
  logic [3:0]  dispense_code;
  logic [15:0] sales_total;

  int errors = 0;
  int checks = 0;
  int exp_sales = 0;
  int price [8] = '{5, 10, 15, 20, 25, 90, 35, 60};

  vend_ctrl_multi #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_code(sel_code),
    .cancel(cancel), .change_ack(change_ack), .sales_clear(sales_clear),
    .price_table(price_table),
    .credit(credit), .coin_reject(coin_reject),
    .dispense(dispense), .dispense_code(dispense_code),
    .change_valid(change_valid), .change_amount(change_amount),
    .alarm(alarm), .sales_total(sales_total)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // All stimulus tasks start and end at a negedge; the posedge in between samples the strobes.
  task automatic drive(input logic c, input int cv, input logic s, input int sc, input logic k);
    coin_valid = c; coin_value = 8'(cv); sel_valid = s; sel_code = 4'(sc); cancel = k;
    @(negedge clk);
    coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
  endtask

  task automatic coin(input int v);      drive(1'b1, v, 1'b0, 0, 1'b0); endtask
  task automatic sel(input int c);       drive(1'b0, 0, 1'b1, c, 1'b0); endtask
  task automatic cancel_req();           drive(1'b0, 0, 1'b0, 0, 1'b1); endtask
  task automatic idle(input int n);      repeat (n) @(negedge clk);     endtask

  task automatic ack();
    change_ack = 1'b1;
    @(negedge clk);
    change_ack = 1'b0;
  endtask

  task automatic count_alarm(output int n, output logic saw_disp);
    n = 0;
    saw_disp = 1'b0;
    while (alarm === 1'b1 && n < 10) begin
      if (dispense === 1'b1) saw_disp = 1'b1;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({credit, coin_reject, dispense, dispense_code, change_valid, change_amount, alarm, sales_total} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got credit=%0d disp=%0b cv=%0b alarm=%0b sales=%0d want all 0", credit, dispense, change_valid, alarm, sales_total);
    end
  endtask

  task automatic test_vend_change();
    coin(10); coin(10);
    checks++; if (credit !== 8'd20) begin errors++; $display("FAIL t1_credit: got %0d want 20", credit); end
    sel(2);
    checks++; if (dispense !== 1'b1 || dispense_code !== 4'd2) begin errors++; $display("FAIL t1_dispense: got disp=%0b code=%0d want 1/2", dispense, dispense_code); end
    idle(1);
    exp_sales += 15;
    checks++; if (dispense !== 1'b0) begin errors++; $display("FAIL t1_disp_width: got %0b want 0", dispense); end
    checks++; if (change_valid !== 1'b1 || change_amount !== 8'd5) begin errors++; $display("FAIL t1_change: got cv=%0b amt=%0d want 1/5", change_valid, change_amount); end
    checks++; if (sales_total !== 16'(exp_sales)) begin errors++; $display("FAIL t1_sales: got %0d want %0d", sales_total, exp_sales); end
    coin(5);
    checks++; if (coin_reject !== 1'b1 || change_valid !== 1'b1 || change_amount !== 8'd5) begin errors++; $display("FAIL t1_coin_in_change: got rej=%0b cv=%0b amt=%0d want 1/1/5", coin_reject, change_valid, change_amount); end
    ack();
    checks++; if (change_valid !== 1'b0 || credit !== 8'd0) begin errors++; $display("FAIL t1_ack: got cv=%0b credit=%0d want 0/0", change_valid, credit); end
  endtask

  task automatic test_alarm_underfunded();
    int n; logic sd;
    coin(10); sel(2);
    count_alarm(n, sd);
    checks++; if (n != 3 || sd) begin errors++; $display("FAIL t2_alarm_len: got %0d cycles disp=%0b want 3/0", n, sd); end
    checks++; if (credit !== 8'd10) begin errors++; $display("FAIL t2_credit_kept: got %0d want 10", credit); end
    coin(5); sel(2);
    checks++; if (dispense !== 1'b1) begin errors++; $display("FAIL t2_dispense: got %0b want 1", dispense); end
    idle(1);
    exp_sales += 15;
    checks++; if (change_valid !== 1'b0 || credit !== 8'd0 || sales_total !== 16'(exp_sales)) begin errors++; $display("FAIL t2_no_change: got cv=%0b credit=%0d sales=%0d want 0/0/%0d", change_valid, credit, sales_total, exp_sales); end
  endtask

  task automatic test_invalid_and_ceiling();
    int n; logic sd;
    coin(20); sel(9);
    count_alarm(n, sd);
    checks++; if (n != 3 || sd) begin errors++; $display("FAIL t3_bad_code: got alarm %0d cycles disp=%0b want 3/0", n, sd); end
    cancel_req();
    checks++; if (change_valid !== 1'b1 || change_amount !== 8'd20) begin errors++; $display("FAIL t3_cancel: got cv=%0b amt=%0d want 1/20", change_valid, change_amount); end
    ack();
    coin(100);
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd0) begin errors++; $display("FAIL t3_idle_over: got rej=%0b credit=%0d want 1/0", coin_reject, credit); end
    coin(50); coin(45); coin(10);
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd95) begin errors++; $display("FAIL t3_ceiling: got rej=%0b credit=%0d want 1/95", coin_reject, credit); end
    coin(4);
    checks++; if (coin_reject !== 1'b0 || credit !== 8'd99) begin errors++; $display("FAIL t3_at_ceiling: got rej=%0b credit=%0d want 0/99", coin_reject, credit); end
    cancel_req(); ack();
  endtask

  task automatic test_timeout_priority();
    coin(30);
    idle(TMO - 1);
    checks++; if (change_valid !== 1'b0) begin errors++; $display("FAIL t4_early_timeout: got cv=%0b want 0", change_valid); end
    idle(1);
    checks++; if (change_valid !== 1'b1 || change_amount !== 8'd30) begin errors++; $display("FAIL t4_timeout: got cv=%0b amt=%0d want 1/30", change_valid, change_amount); end
    ack();
    coin(20);
    drive(1'b1, 5, 1'b1, 0, 1'b1);
    checks++; if (change_valid !== 1'b1 || change_amount !== 8'd20 || coin_reject !== 1'b1 || dispense !== 1'b0) begin errors++; $display("FAIL t4_priority: got cv=%0b amt=%0d rej=%0b disp=%0b want 1/20/1/0", change_valid, change_amount, coin_reject, dispense); end
    ack();
  endtask

  task automatic test_sales_saturation();
    sales_clear = 1'b1; @(negedge clk); sales_clear = 1'b0;
    checks++; if (sales_total !== 16'd0) begin errors++; $display("FAIL t5_clear: got %0d want 0", sales_total); end
    for (int i = 0; i < 728; i++) begin
      coin(90); sel(5); idle(1);
    end
    checks++; if (sales_total !== 16'hFFF0) begin errors++; $display("FAIL t5_accum: got %0h want fff0", sales_total); end
    coin(20); sel(3); idle(1);
    checks++; if (sales_total !== 16'hFFFF) begin errors++; $display("FAIL t5_saturate: got %0h want ffff", sales_total); end
    coin(15); sel(2);
    sales_clear = 1'b1; @(negedge clk); sales_clear = 1'b0;
    checks++; if (sales_total !== 16'd15) begin errors++; $display("FAIL t5_clear_in_vend: got %0d want 15", sales_total); end
    exp_sales = 15;
  endtask

  task automatic test_reset_mid_change();
    coin(20); cancel_req();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({credit, coin_reject, dispense, dispense_code, change_valid, change_amount, alarm, sales_total} !== '0) begin
      errors++;
      $display("FAIL t6_async_reset: got credit=%0d cv=%0b amt=%0d sales=%0d want all 0", credit, change_valid, change_amount, sales_total);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    exp_sales = 0;
    coin(7);
    checks++; if (credit !== 8'd7 || coin_reject !== 1'b0 || change_valid !== 1'b0) begin errors++; $display("FAIL t6_after_reset: got credit=%0d rej=%0b cv=%0b want 7/0/0", credit, coin_reject, change_valid); end
    cancel_req(); ack();
  endtask

  task automatic test_random();
    int cr, v, code, rem, n;
    logic sd, rej;
    for (int t = 0; t < 40; t++) begin
      cr = 0;
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        v = $urandom_range(1, 60);
        rej = (cr + v > 99);
        coin(v);
        if (!rej) cr += v;
        checks++; if (coin_reject !== rej || credit !== 8'(cr)) begin errors++; $display("FAIL rnd_coin[%0d]: got rej=%0b credit=%0d want %0b/%0d", t, coin_reject, credit, rej, cr); end
      end
      code = $urandom_range(0, 9);
      sel(code);
      if (code >= 8 || cr < price[code]) begin
        count_alarm(n, sd);
        checks++; if (n != 3 || sd || credit !== 8'(cr)) begin errors++; $display("FAIL rnd_alarm[%0d]: got %0d cycles disp=%0b credit=%0d want 3/0/%0d", t, n, sd, credit, cr); end
        cancel_req();
        checks++; if (change_valid !== 1'b1 || change_amount !== 8'(cr)) begin errors++; $display("FAIL rnd_refund[%0d]: got cv=%0b amt=%0d want 1/%0d", t, change_valid, change_amount, cr); end
        ack();
      end else begin
        checks++; if (dispense !== 1'b1 || dispense_code !== 4'(code)) begin errors++; $display("FAIL rnd_disp[%0d]: got %0b/%0d want 1/%0d", t, dispense, dispense_code, code); end
        idle(1);
        exp_sales = (exp_sales + price[code] > 65535) ? 65535 : exp_sales + price[code];
        rem = cr - price[code];
        checks++; if (sales_total !== 16'(exp_sales)) begin errors++; $display("FAIL rnd_sales[%0d]: got %0d want %0d", t, sales_total, exp_sales); end
        checks++; if (change_valid !== (rem > 0) || (rem > 0 && change_amount !== 8'(rem))) begin errors++; $display("FAIL rnd_change[%0d]: got cv=%0b amt=%0d want %0b/%0d", t, change_valid, change_amount, rem > 0, rem); end
        if (rem > 0) begin
          idle($urandom_range(0, 3));
          ack();
        end
      end
      checks++; if (credit !== 8'd0 || change_valid !== 1'b0 || alarm !== 1'b0) begin errors++; $display("FAIL rnd_end[%0d]: got credit=%0d cv=%0b alarm=%0b want 0/0/0", t, credit, change_valid, alarm); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    coin_valid = 1'b0; coin_value = '0; sel_valid = 1'b0; sel_code = '0;
    cancel = 1'b0; change_ack = 1'b0; sales_clear = 1'b0;
    for (int i = 0; i < 8; i++) price_table[i*8 +: 8] = 8'(price[i]);
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_vend_change();
    test_alarm_underfunded();
    test_invalid_and_ceiling();
    test_timeout_priority();
    test_sales_saturation();
    test_reset_mid_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
